branch_resolve: RTL and testbench
=================================

# branch_resolve

Registered, parametrised branch-resolution stage for the RV32I pipeline. Evaluates the six conditional-branch comparisons on XLEN-wide operands, checks the result against the fetch-stage prediction, and produces a one-cycle-latency mispredict flag and redirect PC. It obeys the pipeline's stall/flush handshake and keeps saturating branch and mispredict counters for performance monitoring. It sits at the EX/MEM boundary.

## Interface
- WIDTH, 32: operand and PC width in bits (≥ 8).
- CNT_W, 32: width of each performance counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a conditional branch is presented this cycle.
- stall  in  1  hold the stage; inputs ignored, outputs frozen.
- flush  in  1  discard the incoming branch; the stage is empty next cycle.
- cmpop  in  3  branch_funct3_t: beq=000, bne=001, blt=100, bge=101, bltu=110, bgeu=111.
- rs1_val  in  WIDTH  first operand.
- cmp_val  in  WIDTH  second operand (rs2 or forwarded value).
- pred_taken  in  1  fetch-stage prediction for this branch.
- pc  in  WIDTH  branch instruction address.
- target  in  WIDTH  taken-path target address.
- cnt_clr  in  1  synchronous clear of both counters.
- out_valid  out  1  the stage holds a resolved branch.
- br_en  out  1  resolved direction: 1 = taken.
- mispredict  out  1  out_valid && (br_en != registered pred_taken).
- redirect_pc  out  WIDTH  correct next PC: target if br_en, else pc+4.
- branch_count  out  CNT_W  number of resolved branches retired from the stage.
- mispredict_count  out  CNT_W  number of retired branches that mispredicted.

## Operation
- Compare: eq/ne are bitwise over WIDTH bits. blt/bge treat both operands as WIDTH-bit two's complement. bltu/bgeu are unsigned.
- Illegal cmpop values 010 and 011 resolve as not-taken (br_en=0). The branch is still valid and counted.
- Capture enable = in_valid && !stall && !flush. On capture, the stage registers out_valid=1, br_en, pred_taken, and redirect_pc.
- When !stall, !flush and !in_valid, out_valid goes to 0 at the next edge.
- redirect_pc = pc + 4 wraps modulo 2^WIDTH. It is computed combinationally before the register, so it never depends on registered pc.
- mispredict is combinational from registered state and is forced to 0 when out_valid=0.
- Retire event = out_valid && !stall. On a retire event, branch_count increments and, if mispredict is set, mispredict_count increments.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset: out_valid=0, br_en=0, mispredict=0, redirect_pc=0, branch_count=0, mispredict_count=0.
- Latency: 1 cycle. A branch accepted at edge N is visible on outputs after edge N.
- stall=1: every register, including the counters, holds. in_valid and flush are ignored while stalled. Outputs stay stable for the whole stall.
- flush=1 (stall=0): the stage is empty next cycle regardless of in_valid. A branch currently presented with out_valid=1 still retires and is counted on that edge; flush kills only the incoming branch.
- Priority, highest first: rst, stall, flush, capture.
- cnt_clr: both counters become 0 at the next edge. cnt_clr beats a same-cycle retire increment. cnt_clr is ignored during stall.
- Reset mid-stall or mid-branch: all state clears next edge, and no retire is counted on that edge.
- Back-to-back in_valid with stall=0: one branch per cycle, no bubbles.

## Test plan
- Signed/unsigned: rs1=0xFFFFFFFF, cmp=0x00000001, WIDTH=32.
  - blt → br_en=1; bltu → br_en=0.
  - bge → br_en=0; bgeu → br_en=1.
  - Each result appears one cycle after in_valid.
- Mispredict and redirect: beq, rs1=cmp=5, pred_taken=0, pc=0x100, target=0x200 → mispredict=1, redirect_pc=0x200.
  - Same inputs with bne → br_en=0, mispredict=0, redirect_pc=0x104.
- PC wrap: pc=0xFFFFFFFC, not taken → redirect_pc=0x00000000.
- Stall/flush:
  - Capture a branch, then stall for 3 cycles → outputs frozen and branch_count unchanged.
  - Release stall with flush=1 and in_valid=1 → the old branch is counted (branch_count+1) and out_valid=0 next cycle.
- Counter saturation: CNT_W=4, 20 back-to-back mispredicting branches → both counters stick at 15.
  - Then assert cnt_clr together with a retiring branch → both counters read 0.
- Illegal cmpop 010 with pred_taken=1 → br_en=0, mispredict=1, branch_count+1.
  - Finally assert rst during out_valid=1 → all outputs 0 next cycle.

Source files
------------

// File: rtl/branch_resolve.sv
// Registered RV32I branch-resolution stage at the EX/MEM boundary: resolves the
// conditional-branch compare, flags mispredicts, and keeps saturating perf counters.
module branch_resolve #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [2:0]       cmpop,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             pred_taken,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] target,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic             br_en,
    output logic             mispredict,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_funct3_t;

    logic             valid_q, valid_d;
    logic             br_en_q, br_en_d;
    logic             pred_q, pred_d;
    logic [WIDTH-1:0] redirect_q, redirect_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic             taken;
    logic             capture;
    logic             retire;
    logic             mis_now;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        taken = 1'b0;
        case (branch_funct3_t'(cmpop))
            F3_BEQ:  taken = (rs1_val == cmp_val);
            F3_BNE:  taken = (rs1_val != cmp_val);
            F3_BLT:  taken = ($signed(rs1_val) <  $signed(cmp_val));
            F3_BGE:  taken = ($signed(rs1_val) >= $signed(cmp_val));
            F3_BLTU: taken = (rs1_val <  cmp_val);
            F3_BGEU: taken = (rs1_val >= cmp_val);
            default: taken = 1'b0;  // 010/011 are not branches: resolve not-taken
        endcase
    end

    assign capture = in_valid && !stall && !flush;
    assign retire  = valid_q && !stall;
    assign mis_now = valid_q && (br_en_q != pred_q);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        valid_d      = valid_q;
        br_en_d      = br_en_q;
        pred_d       = pred_q;
        redirect_d   = redirect_q;
        branch_cnt_d = branch_cnt_q;
        mis_cnt_d    = mis_cnt_q;

        if (!stall) begin
            valid_d = capture;
            if (capture) begin
                br_en_d    = taken;
                pred_d     = pred_taken;
                redirect_d = taken ? target : pc + WIDTH'(4);
            end

            // A retiring branch leaves even when the incoming one is flushed.
            if (cnt_clr) begin
                branch_cnt_d = '0;
                mis_cnt_d    = '0;
            end else if (retire) begin
                branch_cnt_d = sat_inc(branch_cnt_q);
                if (mis_now) begin
                    mis_cnt_d = sat_inc(mis_cnt_q);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            br_en_q      <= 1'b0;
            pred_q       <= 1'b0;
            redirect_q   <= '0;
            branch_cnt_q <= '0;
            mis_cnt_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            br_en_q      <= br_en_d;
            pred_q       <= pred_d;
            redirect_q   <= redirect_d;
            branch_cnt_q <= branch_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
        end
    end

    assign out_valid        = valid_q;
    assign br_en            = br_en_q;
    assign mispredict       = mis_now;
    assign redirect_pc      = redirect_q;
    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus randomized traffic
// against a behavioural model; a second instance with 4-bit counters covers saturation.
module tb_branch_resolve;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, stall, flush, pred_taken, cnt_clr;
    logic [2:0]   cmpop;
    logic [W-1:0] rs1_val, cmp_val, pc, target;

    logic         out_valid, br_en, mispredict;
    logic [W-1:0] redirect_pc, branch_count, mispredict_count;
    logic         out_valid4, br_en4, mispredict4;
    logic [W-1:0] redirect_pc4;
    logic [3:0]   branch_count4, mispredict_count4;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    bit          m_valid, m_taken, m_pred;
    bit [W-1:0]  m_redirect;
    longint      m_bc, m_mc, m_bc4, m_mc4;

    always #5 clk = ~clk;

    branch_resolve #(.WIDTH(W), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .cmpop(cmpop), .rs1_val(rs1_val), .cmp_val(cmp_val), .pred_taken(pred_taken),
        .pc(pc), .target(target), .cnt_clr(cnt_clr),
        .out_valid(out_valid), .br_en(br_en), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    branch_resolve #(.WIDTH(W), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .cmpop(cmpop), .rs1_val(rs1_val), .cmp_val(cmp_val), .pred_taken(pred_taken),
        .pc(pc), .target(target), .cnt_clr(cnt_clr),
        .out_valid(out_valid4), .br_en(br_en4), .mispredict(mispredict4),
        .redirect_pc(redirect_pc4), .branch_count(branch_count4),
        .mispredict_count(mispredict_count4)
    );

    function automatic longint as_signed(input bit [W-1:0] v);
        return v[W-1] ? longint'(v) - (longint'(1) << W) : longint'(v);
    endfunction

    function automatic bit ref_taken(input bit [2:0] op, input bit [W-1:0] a, input bit [W-1:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        case (op)
            3'b000:  return ua == ub;
            3'b001:  return ua != ub;
            3'b100:  return as_signed(a) <  as_signed(b);
            3'b101:  return as_signed(a) >= as_signed(b);
            3'b110:  return ua <  ub;
            3'b111:  return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic longint sat(input longint v, input longint maxv);
        return (v + 1 > maxv) ? maxv : v + 1;
    endfunction

    // Advances the model by one rising edge using the inputs present before it.
    task automatic model_edge();
        longint pc4;
        if (rst) begin
            m_valid = 0; m_taken = 0; m_pred = 0; m_redirect = '0;
            m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
        end else if (!stall) begin
            if (cnt_clr) begin
                m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
            end else if (m_valid) begin
                m_bc  = sat(m_bc, 64'hFFFF_FFFF);
                m_bc4 = sat(m_bc4, 15);
                if (m_taken != m_pred) begin
                    m_mc  = sat(m_mc, 64'hFFFF_FFFF);
                    m_mc4 = sat(m_mc4, 15);
                end
            end
            if (in_valid && !flush) begin
                m_valid = 1;
                m_taken = ref_taken(cmpop, rs1_val, cmp_val);
                m_pred  = pred_taken;
                pc4     = (longint'(pc) + 4) % (longint'(1) << W);
                m_redirect = m_taken ? target : W'(pc4);
            end else begin
                m_valid = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_branch(input bit [2:0] op, input bit [W-1:0] a, input bit [W-1:0] b,
                              input bit pr, input bit [W-1:0] p, input bit [W-1:0] t);
        in_valid = 1; cmpop = op; rs1_val = a; cmp_val = b;
        pred_taken = pr; pc = p; target = t;
    endtask

    task automatic test_reset();
        rst = 1; tick(); tick(); rst = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (br_en !== 1'b0) begin errors++; $display("FAIL reset_br_en: got %0b want 0", br_en); end
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %0b want 0", mispredict); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect: got %0h want 0", redirect_pc); end
        checks++; if (branch_count !== 32'h0 || mispredict_count !== 32'h0) begin
            errors++; $display("FAIL reset_counters: got %0h/%0h want 0/0", branch_count, mispredict_count); end
    endtask

    task automatic test_signed_unsigned();
        bit [2:0] ops [4]  = '{3'b100, 3'b110, 3'b101, 3'b111};
        bit       want [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            set_branch(ops[i], 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h40 + 32'(i * 4), 32'h800);
            tick();
            checks++; if (out_valid !== 1'b1 || br_en !== want[i]) begin
                errors++; $display("FAIL signed_unsigned op=%03b: got valid=%0b br_en=%0b want 1/%0b", ops[i], out_valid, br_en, want[i]); end
        end
        in_valid = 0; tick();
    endtask

    task automatic test_mispredict_redirect();
        set_branch(3'b000, 32'd5, 32'd5, 1'b0, 32'h100, 32'h200);
        tick();
        checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h200) begin
            errors++; $display("FAIL beq_mispredict: got mis=%0b redirect=%0h want 1/200", mispredict, redirect_pc); end
        set_branch(3'b001, 32'd5, 32'd5, 1'b0, 32'h100, 32'h200);
        tick();
        checks++; if (br_en !== 1'b0 || mispredict !== 1'b0 || redirect_pc !== 32'h104) begin
            errors++; $display("FAIL bne_redirect: got br_en=%0b mis=%0b redirect=%0h want 0/0/104", br_en, mispredict, redirect_pc); end
        set_branch(3'b001, 32'd7, 32'd7, 1'b0, 32'hFFFF_FFFC, 32'h300);
        tick();
        checks++; if (redirect_pc !== 32'h0) begin
            errors++; $display("FAIL pc_wrap: got redirect=%0h want 0", redirect_pc); end
        in_valid = 0; tick();
    endtask

    task automatic test_stall_flush();
        bit [W-1:0] held_redirect;
        longint     held_bc;
        set_branch(3'b110, 32'd1, 32'd2, 1'b0, 32'h1000, 32'h2000);
        tick();
        held_redirect = m_redirect;
        held_bc = m_bc;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_branch(3'b000, $urandom, $urandom, 1'b1, $urandom, $urandom);
            flush = i[0]; cnt_clr = i[1];
            tick();
            checks++; if (out_valid !== 1'b1 || br_en !== 1'b1 || mispredict !== 1'b1 ||
                          redirect_pc !== held_redirect || branch_count !== W'(held_bc)) begin
                errors++; $display("FAIL stall_hold[%0d]: got v=%0b br=%0b mis=%0b pc=%0h cnt=%0d want 1/1/1/%0h/%0d",
                                   i, out_valid, br_en, mispredict, redirect_pc, branch_count, held_redirect, held_bc); end
        end
        stall = 0; flush = 1; cnt_clr = 0; in_valid = 1;
        tick();
        checks++; if (out_valid !== 1'b0 || branch_count !== W'(held_bc + 1)) begin
            errors++; $display("FAIL flush_retire: got v=%0b cnt=%0d want 0/%0d", out_valid, branch_count, held_bc + 1); end
        flush = 0; in_valid = 0; tick();
    endtask

    task automatic test_saturation();
        cnt_clr = 1; tick(); cnt_clr = 0;
        set_branch(3'b000, 32'd9, 32'd9, 1'b0, 32'h500, 32'h600);
        for (int i = 0; i < 20; i++) tick();
        checks++; if (branch_count4 !== 4'd15 || mispredict_count4 !== 4'd15) begin
            errors++; $display("FAIL saturate4: got %0d/%0d want 15/15", branch_count4, mispredict_count4); end
        checks++; if (branch_count !== 32'd19 || mispredict_count !== 32'd19) begin
            errors++; $display("FAIL count32: got %0d/%0d want 19/19", branch_count, mispredict_count); end
        cnt_clr = 1; tick(); cnt_clr = 0;
        checks++; if (branch_count4 !== 4'd0 || mispredict_count4 !== 4'd0 || branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
            errors++; $display("FAIL clr_beats_retire: got %0d/%0d %0d/%0d want all 0",
                               branch_count4, mispredict_count4, branch_count, mispredict_count); end
        in_valid = 0; tick();
    endtask

    task automatic test_illegal_and_reset();
        longint bc_before;
        set_branch(3'b010, $urandom, $urandom, 1'b1, 32'h700, 32'h900);
        tick();
        checks++; if (out_valid !== 1'b1 || br_en !== 1'b0 || mispredict !== 1'b1) begin
            errors++; $display("FAIL illegal_cmpop: got v=%0b br=%0b mis=%0b want 1/0/1", out_valid, br_en, mispredict); end
        bc_before = m_bc;
        set_branch(3'b011, 32'h1, 32'h1, 1'b0, 32'h704, 32'h900);
        tick();
        checks++; if (branch_count !== W'(bc_before + 1) || br_en !== 1'b0) begin
            errors++; $display("FAIL illegal_counted: got cnt=%0d br=%0b want %0d/0", branch_count, br_en, bc_before + 1); end
        stall = 1; rst = 1; tick(); rst = 0; stall = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0 || br_en !== 1'b0 || mispredict !== 1'b0 || redirect_pc !== 32'h0 ||
                      branch_count !== 32'h0 || mispredict_count !== 32'h0) begin
            errors++; $display("FAIL reset_mid_branch: got v=%0b br=%0b mis=%0b pc=%0h cnt=%0d/%0d want all 0",
                               out_valid, br_en, mispredict, redirect_pc, branch_count, mispredict_count); end
    endtask

    task automatic test_random();
        bit [W-1:0] a, b;
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = ~a;
                2: b = a ^ 32'h8000_0000;
                default: b = $urandom;
            endcase
            set_branch(3'($urandom), a, b, 1'($urandom), $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) pc = 32'hFFFF_FFFC;
            in_valid = ($urandom_range(0, 9) < 8);
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            cnt_clr  = ($urandom_range(0, 29) == 0);
            rst      = ($urandom_range(0, 59) == 0);
            tick();
            checks++; if (out_valid !== m_valid || mispredict !== (m_valid && (m_taken != m_pred))) begin
                errors++; $display("FAIL rand_valid[%0d]: got v=%0b mis=%0b want %0b/%0b", i, out_valid, mispredict,
                                   m_valid, m_valid && (m_taken != m_pred)); end
            if (m_valid) begin
                checks++; if (br_en !== m_taken || redirect_pc !== m_redirect) begin
                    errors++; $display("FAIL rand_result[%0d]: got br=%0b pc=%0h want %0b/%0h", i, br_en, redirect_pc, m_taken, m_redirect); end
            end
            checks++; if (branch_count !== W'(m_bc) || mispredict_count !== W'(m_mc)) begin
                errors++; $display("FAIL rand_cnt32[%0d]: got %0d/%0d want %0d/%0d", i, branch_count, mispredict_count, m_bc, m_mc); end
            checks++; if (branch_count4 !== 4'(m_bc4) || mispredict_count4 !== 4'(m_mc4)) begin
                errors++; $display("FAIL rand_cnt4[%0d]: got %0d/%0d want %0d/%0d", i, branch_count4, mispredict_count4, m_bc4, m_mc4); end
        end
        rst = 0; stall = 0; flush = 0; cnt_clr = 0; in_valid = 0;
        tick();
    endtask

    initial begin
        rst = 1; in_valid = 0; stall = 0; flush = 0; cnt_clr = 0; pred_taken = 0;
        cmpop = '0; rs1_val = '0; cmp_val = '0; pc = '0; target = '0;
        test_reset();
        test_signed_unsigned();
        test_mispredict_redirect();
        test_stall_flush();
        test_saturation();
        test_illegal_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
